// File: rtl/arb2_pkg.sv
// -----------------------------------------------------------------------------
// arb2_pkg -- shared definitions for the two-channel arbiter (arb2_sel).
//
// Contents:
//   WIDTH_DEF : default data width of each channel and of the output word
//   state_t   : output-register occupancy (EMPTY / FULL)
//   ch_t      : channel index; the encoding matches the mux2 select
//               (CH_A1 = 0 selects input a, CH_A2 = 1 selects input b)
// -----------------------------------------------------------------------------
package arb2_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef enum logic {
        CH_A1 = 1'b0,
        CH_A2 = 1'b1
    } ch_t;

endpackage : arb2_pkg

// File: rtl/mux2.sv
// -----------------------------------------------------------------------------
// mux2 -- purely combinational two-input word multiplexer.
//
// Parameters:
//   WIDTH : data width
// Ports:
//   a  in  [WIDTH-1:0]  word selected when s = 0
//   b  in  [WIDTH-1:0]  word selected when s = 1
//   s  in  1            select
//   y  out [WIDTH-1:0]  selected word
// -----------------------------------------------------------------------------
module mux2 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? b : a;

endmodule : mux2

// File: rtl/arb2_sel.sv
// -----------------------------------------------------------------------------
// arb2_sel -- two-channel arbiter feeding a one-entry output register.
//
// The winning channel's word is steered through mux2 and captured in y on the
// accepting clock edge; s records which channel that word came from. The
// register drains and reloads on the same edge, so one word per cycle is
// sustained while downstream keeps y_ready high.
//
// Configuration:
//   ARB2_RR_EN defined   : simultaneous requests resolved round-robin (the
//                          channel not granted last wins; a1 first after reset)
//   ARB2_RR_EN undefined : a1 always wins simultaneous requests; no pointer
//                          register exists
//
// Parameters:
//   WIDTH : data width of each channel and of y
// Ports:
//   clk       in   1        rising-edge clock
//   reset     in   1        asynchronous, active-high reset
//   a1        in   [WIDTH]  channel-1 data
//   a1_valid  in   1        channel-1 request
//   a1_ready  out  1        channel-1 grant/accept (combinational)
//   a2        in   [WIDTH]  channel-2 data
//   a2_valid  in   1        channel-2 request
//   a2_ready  out  1        channel-2 grant/accept (combinational)
//   s         out  1        source of the word in y (0 = a1, 1 = a2)
//   y         out  [WIDTH]  held word
//   y_valid   out  1        y holds data
//   y_ready   in   1        downstream accept
// -----------------------------------------------------------------------------
module arb2_sel
    import arb2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a1,
    input  logic             a1_valid,
    output logic             a1_ready,
    input  logic [WIDTH-1:0] a2,
    input  logic             a2_valid,
    output logic             a2_ready,
    output logic             s,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready
);

    state_t           state;
    state_t           state_next;
    ch_t              grant;
    ch_t              prio;
    ch_t              sel_q;
    logic [WIDTH-1:0] mux_y;
    logic [WIDTH-1:0] y_q;
    logic             load_ok;
    logic             take;

    // -------------------------------------------------------------------------
    // Priority source for simultaneous requests
    // -------------------------------------------------------------------------
`ifdef ARB2_RR_EN
    ch_t ptr;

    // The pointer names the channel that wins the next tie. It only moves on a
    // completed transfer, and always to the channel that was not just served.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= CH_A1;
        end else if (take) begin
            if (grant == CH_A1) begin
                ptr <= CH_A2;
            end else begin
                ptr <= CH_A1;
            end
        end
    end

    assign prio = ptr;
`else
    assign prio = CH_A1;
`endif

    // -------------------------------------------------------------------------
    // Grant selection and steering
    // -------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = CH_A1;
        if (a1_valid && a2_valid) begin
            grant = prio;
        end else if (a2_valid) begin
            grant = CH_A2;
        end
    end

    mux2 #(
        .WIDTH(WIDTH)
    ) u_mux2 (
        .a(a1),
        .b(a2),
        .s(grant == CH_A2),
        .y(mux_y)
    );

    // The register can take a word when empty, or when full and draining on
    // this edge. Reset is folded in so both readies stay low while it is held.
    assign load_ok  = (state == EMPTY) || y_ready;
    assign take     = !reset && load_ok && (a1_valid || a2_valid);
    assign a1_ready = take && (grant == CH_A1);
    assign a2_ready = take && (grant == CH_A2);

    // -------------------------------------------------------------------------
    // Occupancy FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (take) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                // Drain with a simultaneous reload keeps the register full.
                if (y_ready) begin
                    state_next = take ? FULL : EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output register: y and s change only on an accepted transfer, so a drain
    // without reload leaves the last word visible.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q   <= '0;
            sel_q <= CH_A1;
        end else if (take) begin
            y_q   <= mux_y;
            sel_q <= grant;
        end
    end

    assign y       = y_q;
    assign s       = (sel_q == CH_A2);
    assign y_valid = (state == FULL);

endmodule : arb2_sel

// File: tb/tb_arb2_sel.sv
// -----------------------------------------------------------------------------
// tb_arb2_sel -- directed self-checking bench for arb2_sel (WIDTH = 4).
//
// Inputs change at posedge+1 and outputs are compared between edges. The
// simultaneous-request expectations follow ARB2_RR_EN, so the same bench
// checks either build.
// -----------------------------------------------------------------------------
module tb_arb2_sel;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] a1;
    logic         a1_valid;
    logic         a1_ready;
    logic [W-1:0] a2;
    logic         a2_valid;
    logic         a2_ready;
    logic         s;
    logic [W-1:0] y;
    logic         y_valid;
    logic         y_ready;

    int n_vec;
    int n_err;

    arb2_sel #(
        .WIDTH(W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .a1      (a1),
        .a1_valid(a1_valid),
        .a1_ready(a1_ready),
        .a2      (a2),
        .a2_valid(a2_valid),
        .a2_ready(a2_ready),
        .s       (s),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held: outputs cleared and no grant even with a request pending.
    task automatic test_reset();
        reset    = 1'b1;
        a1       = 4'b1111;
        a1_valid = 1'b1;
        #2;
        n_vec++; if (y !== 4'b0000) begin n_err++; $display("FAIL reset_y: got %b expected 0000", y); end
        n_vec++; if (y_valid !== 1'b0) begin n_err++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
        n_vec++; if (s !== 1'b0) begin n_err++; $display("FAIL reset_s: got %b expected 0", s); end
        n_vec++; if (a1_ready !== 1'b0) begin n_err++; $display("FAIL reset_a1_ready: got %b expected 0", a1_ready); end
        n_vec++; if (a2_ready !== 1'b0) begin n_err++; $display("FAIL reset_a2_ready: got %b expected 0", a2_ready); end
        tick();
        n_vec++; if (y_valid !== 1'b0) begin n_err++; $display("FAIL reset_edge_y_valid: got %b expected 0", y_valid); end
        reset    = 1'b0;
        a1_valid = 1'b0;
        tick();
    endtask

    // a1 alone with y_ready=1, then drain with no requests.
    task automatic test_single_and_drain();
        a1       = 4'b1111;
        a1_valid = 1'b1;
        y_ready  = 1'b1;
        #1;
        n_vec++; if (a1_ready !== 1'b1) begin n_err++; $display("FAIL single_a1_ready: got %b expected 1", a1_ready); end
        n_vec++; if (a2_ready !== 1'b0) begin n_err++; $display("FAIL single_a2_ready: got %b expected 0", a2_ready); end
        tick();
        n_vec++; if (y !== 4'b1111) begin n_err++; $display("FAIL single_y: got %b expected 1111", y); end
        n_vec++; if (s !== 1'b0) begin n_err++; $display("FAIL single_s: got %b expected 0", s); end
        n_vec++; if (y_valid !== 1'b1) begin n_err++; $display("FAIL single_y_valid: got %b expected 1", y_valid); end
        a1_valid = 1'b0;
        #1;
        n_vec++; if (a1_ready !== 1'b0) begin n_err++; $display("FAIL drain_a1_ready: got %b expected 0", a1_ready); end
        tick();
        n_vec++; if (y_valid !== 1'b0) begin n_err++; $display("FAIL drain_y_valid: got %b expected 0", y_valid); end
        n_vec++; if (y !== 4'b1111) begin n_err++; $display("FAIL drain_y_hold: got %b expected 1111", y); end
    endtask

    // Back-pressure: full with y_ready=0 for 5 cycles while a2 waits.
    task automatic test_hold();
        a1       = 4'b1010;
        a1_valid = 1'b1;
        y_ready  = 1'b1;
        tick();
        a1_valid = 1'b0;
        n_vec++; if (y !== 4'b1010) begin n_err++; $display("FAIL hold_load_y: got %b expected 1010", y); end
        y_ready  = 1'b0;
        a2       = 4'b0101;
        a2_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++; if (a2_ready !== 1'b0) begin n_err++; $display("FAIL hold_a2_ready[%0d]: got %b expected 0", i, a2_ready); end
            tick();
            n_vec++; if (y !== 4'b1010) begin n_err++; $display("FAIL hold_y[%0d]: got %b expected 1010", i, y); end
            n_vec++; if (y_valid !== 1'b1) begin n_err++; $display("FAIL hold_y_valid[%0d]: got %b expected 1", i, y_valid); end
            n_vec++; if (s !== 1'b0) begin n_err++; $display("FAIL hold_s[%0d]: got %b expected 0", i, s); end
        end
        y_ready = 1'b1;
        #1;
        n_vec++; if (a2_ready !== 1'b1) begin n_err++; $display("FAIL release_a2_ready: got %b expected 1", a2_ready); end
        tick();
        n_vec++; if (y !== 4'b0101) begin n_err++; $display("FAIL release_y: got %b expected 0101", y); end
        n_vec++; if (s !== 1'b1) begin n_err++; $display("FAIL release_s: got %b expected 1", s); end
        n_vec++; if (y_valid !== 1'b1) begin n_err++; $display("FAIL release_y_valid: got %b expected 1", y_valid); end
        a2_valid = 1'b0;
        tick();
    endtask

    // Reset mid-FULL: held word discarded before any edge; first edge after
    // release behaves as EMPTY even with y_ready=0.
    task automatic test_reset_mid();
        a2       = 4'b1111;
        a2_valid = 1'b1;
        y_ready  = 1'b0;
        tick();
        a2_valid = 1'b1;
        n_vec++; if (y !== 4'b1111 || s !== 1'b1) begin n_err++; $display("FAIL mid_preload: got y=%b s=%b expected y=1111 s=1", y, s); end
        #2;
        reset = 1'b1;
        #1;
        n_vec++; if (y !== 4'b0000) begin n_err++; $display("FAIL mid_reset_y: got %b expected 0000", y); end
        n_vec++; if (y_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_y_valid: got %b expected 0", y_valid); end
        n_vec++; if (s !== 1'b0) begin n_err++; $display("FAIL mid_reset_s: got %b expected 0", s); end
        n_vec++; if (a2_ready !== 1'b0) begin n_err++; $display("FAIL mid_reset_a2_ready: got %b expected 0", a2_ready); end
        @(negedge clk);
        reset    = 1'b0;
        a2_valid = 1'b0;
        a1       = 4'b0011;
        a1_valid = 1'b1;
        #1;
        n_vec++; if (a1_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_a1_ready: got %b expected 1", a1_ready); end
        tick();
        n_vec++; if (y !== 4'b0011) begin n_err++; $display("FAIL post_reset_y: got %b expected 0011", y); end
        n_vec++; if (s !== 1'b0) begin n_err++; $display("FAIL post_reset_s: got %b expected 0", s); end
        a1_valid = 1'b0;
        y_ready  = 1'b1;
        tick();
    endtask

    // Both channels held valid with y_ready=1, starting from a fresh reset.
    task automatic test_back_to_back();
        logic [W-1:0] exp_y;
        logic         exp_s;
        reset = 1'b1;
        #2;
        reset    = 1'b0;
        a1       = 4'b1111;
        a2       = 4'b0000;
        a1_valid = 1'b1;
        a2_valid = 1'b1;
        y_ready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
`ifdef ARB2_RR_EN
            exp_s = (i % 2 == 1);
`else
            exp_s = 1'b0;
`endif
            exp_y = exp_s ? 4'b0000 : 4'b1111;
            #1;
            n_vec++; if (a1_ready !== !exp_s) begin n_err++; $display("FAIL b2b_a1_ready[%0d]: got %b expected %b", i, a1_ready, !exp_s); end
            n_vec++; if (a2_ready !== exp_s) begin n_err++; $display("FAIL b2b_a2_ready[%0d]: got %b expected %b", i, a2_ready, exp_s); end
            tick();
            n_vec++; if (y !== exp_y) begin n_err++; $display("FAIL b2b_y[%0d]: got %b expected %b", i, y, exp_y); end
            n_vec++; if (s !== exp_s) begin n_err++; $display("FAIL b2b_s[%0d]: got %b expected %b", i, s, exp_s); end
            n_vec++; if (y_valid !== 1'b1) begin n_err++; $display("FAIL b2b_y_valid[%0d]: got %b expected 1", i, y_valid); end
        end
        a1_valid = 1'b0;
        a2_valid = 1'b0;
        tick();
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b1;
        a1       = '0;
        a2       = '0;
        a1_valid = 1'b0;
        a2_valid = 1'b0;
        y_ready  = 1'b0;

        test_reset();
        test_single_and_drain();
        test_hold();
        test_reset_mid();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_arb2_sel

// File: doc/arb2_sel.md
ARB2_SEL -- requirements
Module: arb2_sel

Interface
REQ-001 The block SHALL have parameter: WIDTH, 4, data width of each channel and of y.
REQ-002 The block SHALL have ports: clk  input  1  rising-edge clock.
REQ-003 The block SHALL have ports: reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have ports: a1  input  WIDTH  channel-1 data.
REQ-005 The block SHALL have ports: a1_valid  input  1  channel-1 request; a1_ready  output  1  channel-1 grant/accept.
REQ-006 The block SHALL have ports: a2  input  WIDTH  channel-2 data.
REQ-007 The block SHALL have ports: a2_valid  input  1  channel-2 request; a2_ready  output  1  channel-2 grant/accept.
REQ-008 The block SHALL have ports: s  output  1  registered select of the word held in y (0 = a1, 1 = a2), mux2-compatible.
REQ-009 The block SHALL have ports: y  output  WIDTH  held word; y_valid  output  1  y holds data; y_ready  input  1  downstream accept.

Function
REQ-010 The block SHALL be a two-channel arbiter that steers the granted channel's word, as mux2 does, into a one-entry output register.
REQ-011 States SHALL be EMPTY (y_valid=0) and FULL (y_valid=1).
REQ-012 The register SHALL be loadable ("load") when state is EMPTY, or when state is FULL and y_ready=1.
REQ-013 When load is possible and at least one channel is valid, exactly one of a1_ready/a2_ready SHALL be 1, driven combinationally, to the winner; otherwise both SHALL be 0.
REQ-014 A transfer SHALL occur on a rising clk edge with the winner's valid and ready both 1: y takes the winner's data, s takes the winner index, and state becomes FULL; latency from accept to y_valid SHALL be 1 cycle.
REQ-015 If state is FULL, y_ready=1 and no channel is valid, state SHALL become EMPTY; y and s SHALL hold their last values.
REQ-016 If state is FULL, y_ready=1 and a channel is valid, the drain and the new load SHALL happen on the same edge, with no bubble (one word per cycle sustained).
REQ-017 If state is FULL and y_ready=0, y, s and y_valid SHALL hold, and both readies SHALL be 0.
REQ-018 If only one channel is valid, that channel SHALL win.
REQ-019 If both are valid, the winner SHALL follow REQ-026/REQ-027.
REQ-020 A loser's valid and data SHALL be ignored that cycle; upstream SHALL hold data stable while valid=1 and ready=0.
REQ-021 The priority pointer SHALL update only on a completed transfer.

Reset
REQ-022 Asserting reset SHALL immediately force y=0, s=0, y_valid=0, state EMPTY, and pointer to "a1 next", independent of clk.
REQ-023 Readies SHALL be 0 while reset=1.
REQ-024 A held word SHALL be discarded on reset mid-operation.
REQ-025 The first edge after deassertion SHALL behave as EMPTY.

Configuration
REQ-026 With ARB2_RR_EN defined, simultaneous requests SHALL be resolved round-robin: the channel not granted last SHALL win, starting with a1 after reset.
REQ-027 Without ARB2_RR_EN, a1 SHALL always win simultaneous requests (fixed priority), and no pointer register SHALL be synthesised.

Structure
REQ-028 A shared package arb2_pkg SHALL hold the default WIDTH constant, the state enum (EMPTY, FULL) and the channel-index type (CH_A1=0, CH_A2=1).
REQ-029 Data steering SHALL reuse the existing mux2 as the single sub-module, with its s driven by the next-grant index; the output register and FSM SHALL live in arb2_sel.

Verification
REQ-030 The bench SHALL cover: reset asserted mid-FULL with y=1111 -> y=0000, y_valid=0 and s=0 immediately, before any clk edge.
REQ-031 The bench SHALL cover: a1=1111 valid alone with y_ready=1 -> a1_ready=1; next cycle y=1111, s=0, y_valid=1.
REQ-032 The bench SHALL cover: a1=1111 and a2=0000 both held valid with y_ready=1 under ARB2_RR_EN -> y alternates 1111/0000 and s alternates 0/1 every cycle, first word 1111.
REQ-033 The bench SHALL cover the same stimulus without ARB2_RR_EN -> y=1111 and s=0 every cycle, with a2_ready never 1.
REQ-034 The bench SHALL cover: FULL with y=1010 and y_ready=0 for 5 cycles while a2=0101 is valid -> y holds 1010 and a2_ready=0; once y_ready=1, the next cycle gives y=0101, s=1.
REQ-035 The bench SHALL cover: FULL, y_ready=1 and no valid inputs -> y_valid=0 next cycle, y unchanged.
